padctl_in_filter: RTL and testbench
===================================

Name: padctl_in_filter

Overview:
- Input-conditioning stage directly downstream of the pad controller.
- Consumes raw pad-to-device inputs: GPIO p2d bus and DPS6/DPS7 straps (jtag_spi_n, boot_strap).
- Per bit: 2-flop synchronisation, programmable glitch filter, edge-pulse generation.
- Samples the two boot straps once after reset, holds them stable for the core, and re-samples on request.

Parameters:
NUM_IN, 32, number of conditioned input bits (width of GPIO p2d bus)
FILT_CNT_W, 4, width of per-bit glitch counter and threshold
STRAP_WAIT, 16, cycles from reset release to strap latch; legal range 3..2^16-1

Ports:
clk_i  in  1  system clock; only clock
rst_i  in  1  synchronous active-high reset
in_raw_i  in  NUM_IN  raw asynchronous pad inputs (cio_gpio_p2d)
filt_en_i  in  NUM_IN  per-bit filter enable; 0 = bypass after sync
filt_thresh_i  in  FILT_CNT_W  stable cycles required beyond first mismatch
in_sync_o  out  NUM_IN  synchronised inputs
in_filt_o  out  NUM_IN  filtered inputs
rise_o  out  NUM_IN  1-cycle pulse, filtered 0->1
fall_o  out  NUM_IN  1-cycle pulse, filtered 1->0
strap_jtag_spi_n_i  in  1  raw jtag/spi select strap pin
strap_boot_i  in  1  raw boot strap pin
strap_resample_i  in  1  1-cycle request to re-sample straps
strap_valid_o  out  1  straps latched and stable
strap_jtag_spi_n_o  out  1  latched jtag_spi_n
strap_boot_o  out  1  latched boot_strap

Behaviour:
- Reset: clk_i is the only clock; reset is synchronous, active-high on rst_i. All flops clear to 0, so every output resets to 0. Strap FSM enters WAIT with its counter at 0.
- Sync: two flops per bit, including both strap pins. in_sync_o lags in_raw_i by 2 edges.
- Filter state per bit: filt_q (= in_filt_o), cnt[FILT_CNT_W-1:0].
- filt_en_i[i]=0: filt_q <= in_sync each edge; cnt <= 0.
- filt_en_i[i]=1, in_sync == filt_q: cnt <= 0.
- filt_en_i[i]=1, in_sync != filt_q, cnt >= filt_thresh_i: filt_q <= in_sync; cnt <= 0.
- filt_en_i[i]=1, in_sync != filt_q, otherwise: cnt <= cnt+1.
- Filter latency: a change held stable is accepted thresh+1 edges after it appears on in_sync_o. Use >= so that lowering the threshold mid-count never hangs. cnt never wraps.
- Edges: prev_q <= filt_q each edge.
  - rise_o = filt_q & ~prev_q; fall_o = ~filt_q & prev_q.
  - Each pulse is exactly one cycle, coincident with the first cycle of the new in_filt_o value. Never both set on one bit.
- Strap FSM, states WAIT and DONE:
  - WAIT: scnt increments each edge. At an edge where scnt == STRAP_WAIT-1, latch the synchronised straps into the outputs, set strap_valid_o=1, go to DONE.
  - DONE: outputs held constant regardless of pin activity.
  - strap_resample_i=1 in DONE: next edge clears strap_valid_o, scnt <= 0, go to WAIT. Latched values are held until the next latch.
  - strap_resample_i=1 in WAIT: scnt <= 0, i.e. wait restarts.
- Strap timing: strap_valid_o rises on the STRAP_WAIT-th edge after the first edge with rst_i sampled low. STRAP_WAIT >= 3 guarantees the synchroniser reflects the pins.
- Reset mid-operation: any cycle with rst_i=1 overrides all other inputs; state returns to reset values on that edge.

Test Plan:
- Reset release, straps jtag_spi_n=1, boot=0, STRAP_WAIT=16 -> strap_valid_o=0 for 15 edges, =1 on 16th with jtag_spi_n_o=1, boot_o=0; later pin toggles leave outputs unchanged.
- Bit 3: filt_en=1, thresh=4; pulse in_raw 0->1 lasting 4 cycles -> in_filt_o[3] stays 0, no rise_o. Level held 10 cycles -> in_filt_o[3]=1 exactly 7 edges after raw change (2 sync + 5 filter), with a single rise_o[3] pulse.
- Bit 0: filt_en=0; raw toggles every cycle -> in_filt_o[0] follows raw delayed 3 edges; rise_o/fall_o alternate one per cycle, never overlapping.
- DONE, boot pin flipped to 1, strap_resample_i pulse -> strap_valid_o low next edge, high 16 edges later with boot_o=1. Second resample at WAIT count 10 -> valid delayed a full 16 from that pulse.
- thresh=15, mismatch counted to 12, thresh changed to 5 -> accept on next edge. rst_i asserted during WAIT at count 8 -> all outputs 0 next edge, count restarts from 0.
- NUM_IN=32, all bits driven with independent random glitches -> per-bit reference model matches in_filt_o, rise_o and fall_o every cycle.

Source files
------------

// File: rtl/padctl_in_filter.sv
// Input conditioning behind the pad controller: per-bit 2-flop sync, glitch filter
// and edge pulses, plus a one-shot boot-strap sampler with a re-sample request.
module padctl_in_filter #(
  parameter int NUM_IN     = 32,
  parameter int FILT_CNT_W = 4,
  parameter int STRAP_WAIT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_IN-1:0]     in_raw_i,
  input  logic [NUM_IN-1:0]     filt_en_i,
  input  logic [FILT_CNT_W-1:0] filt_thresh_i,
  output logic [NUM_IN-1:0]     in_sync_o,
  output logic [NUM_IN-1:0]     in_filt_o,
  output logic [NUM_IN-1:0]     rise_o,
  output logic [NUM_IN-1:0]     fall_o,
  input  logic                  strap_jtag_spi_n_i,
  input  logic                  strap_boot_i,
  input  logic                  strap_resample_i,
  output logic                  strap_valid_o,
  output logic                  strap_jtag_spi_n_o,
  output logic                  strap_boot_o
);

  localparam int SCNT_W = 16;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_DONE = 1'b1
  } strap_state_e;

  logic [NUM_IN-1:0]     sync1_q, sync2_q;
  logic [NUM_IN-1:0]     filt_q, filt_d;
  logic [NUM_IN-1:0]     prev_q;
  logic [FILT_CNT_W-1:0] cnt_q [NUM_IN];
  logic [FILT_CNT_W-1:0] cnt_d [NUM_IN];

  // Strap sync vectors: bit 1 = jtag_spi_n, bit 0 = boot.
  logic [1:0]        strap_sync1_q, strap_sync2_q;
  strap_state_e      state_q, state_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              valid_q, valid_d;
  logic              jtag_q, jtag_d;
  logic              boot_q, boot_d;

  // Filter next state. A change must be seen on thresh+1 consecutive edges; the
  // >= compare lets a threshold lowered mid-count accept at once instead of stalling.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    filt_d = filt_q;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_d[i] = '0;
      if (!filt_en_i[i]) begin
        filt_d[i] = sync2_q[i];
      end else if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] >= filt_thresh_i) filt_d[i] = sync2_q[i];
        else                           cnt_d[i]  = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      prev_q  <= '0;
      // NOTE: the counter array is reset explicitly; it is flop state feeding a
      // compare, not a RAM, and a stale count would shorten the first filter window.
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= in_raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign in_sync_o = sync2_q;
  assign in_filt_o = filt_q;
  assign rise_o    = filt_q & ~prev_q;
  assign fall_o    = ~filt_q & prev_q;

  // Strap sampler: count STRAP_WAIT edges after reset (or re-sample), then latch
  // the synchronised pins and hold them until the next latch.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    valid_d = valid_q;
    jtag_d  = jtag_q;
    boot_d  = boot_q;
    case (state_q)
      S_WAIT: begin
        if (strap_resample_i) begin
          scnt_d = '0;
        end else if (scnt_q == SCNT_W'(STRAP_WAIT - 1)) begin
          jtag_d  = strap_sync2_q[1];
          boot_d  = strap_sync2_q[0];
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (strap_resample_i) begin
          valid_d = 1'b0;
          scnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      strap_sync1_q <= '0;
      strap_sync2_q <= '0;
      state_q       <= S_WAIT;
      scnt_q        <= '0;
      valid_q       <= 1'b0;
      jtag_q        <= 1'b0;
      boot_q        <= 1'b0;
    end else begin
      strap_sync1_q <= {strap_jtag_spi_n_i, strap_boot_i};
      strap_sync2_q <= strap_sync1_q;
      state_q       <= state_d;
      scnt_q        <= scnt_d;
      valid_q       <= valid_d;
      jtag_q        <= jtag_d;
      boot_q        <= boot_d;
    end
  end

  assign strap_valid_o      = valid_q;
  assign strap_jtag_spi_n_o = jtag_q;
  assign strap_boot_o       = boot_q;

endmodule

// File: tb/tb_padctl_in_filter.sv
// Directed bench for padctl_in_filter: strap timing, filter latency/glitch
// rejection, bypass edges, threshold change, reset mid-wait, random model compare.
module tb_padctl_in_filter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] in_raw_i;
  logic [31:0] filt_en_i;
  logic [3:0]  filt_thresh_i;
  logic [31:0] in_sync_o, in_filt_o, rise_o, fall_o;
  logic        strap_jtag_spi_n_i, strap_boot_i, strap_resample_i;
  logic        strap_valid_o, strap_jtag_spi_n_o, strap_boot_o;

  int n_checks = 0;
  int n_errors = 0;

  padctl_in_filter #(.NUM_IN(32), .FILT_CNT_W(4), .STRAP_WAIT(16)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .in_raw_i           (in_raw_i),
    .filt_en_i          (filt_en_i),
    .filt_thresh_i      (filt_thresh_i),
    .in_sync_o          (in_sync_o),
    .in_filt_o          (in_filt_o),
    .rise_o             (rise_o),
    .fall_o             (fall_o),
    .strap_jtag_spi_n_i (strap_jtag_spi_n_i),
    .strap_boot_i       (strap_boot_i),
    .strap_resample_i   (strap_resample_i),
    .strap_valid_o      (strap_valid_o),
    .strap_jtag_spi_n_o (strap_jtag_spi_n_o),
    .strap_boot_o       (strap_boot_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs are changed 1 ns after a rising edge and outputs are sampled there too.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sync"},  in_sync_o, 32'h0);
    check({tag, "_filt"},  in_filt_o, 32'h0);
    check({tag, "_rise"},  rise_o, 32'h0);
    check({tag, "_fall"},  fall_o, 32'h0);
    check({tag, "_valid"}, 32'(strap_valid_o), 32'h0);
    check({tag, "_jtag"},  32'(strap_jtag_spi_n_o), 32'h0);
    check({tag, "_boot"},  32'(strap_boot_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic        hist [0:12];
    logic [31:0] m_s1, m_s2, m_filt, m_prev;
    int          m_cnt [32];
    logic [31:0] cap_en, cap_raw;
    logic [3:0]  cap_th;

    rst_i = 1'b1; in_raw_i = '0; filt_en_i = '0; filt_thresh_i = '0;
    strap_jtag_spi_n_i = 1'b1; strap_boot_i = 1'b0; strap_resample_i = 1'b0;
    tick(); tick();
    check_all_zero("reset");

    // Strap latch 16 edges after reset release.
    rst_i = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("strap_wait_valid", 32'(strap_valid_o), 32'h0);
    end
    tick();
    check("strap_latch_valid", 32'(strap_valid_o), 32'h1);
    check("strap_latch_jtag",  32'(strap_jtag_spi_n_o), 32'h1);
    check("strap_latch_boot",  32'(strap_boot_o), 32'h0);

    strap_jtag_spi_n_i = 1'b0; strap_boot_i = 1'b1;
    repeat (5) tick();
    check("strap_hold_valid", 32'(strap_valid_o), 32'h1);
    check("strap_hold_jtag",  32'(strap_jtag_spi_n_o), 32'h1);
    check("strap_hold_boot",  32'(strap_boot_o), 32'h0);

    // Re-sample from DONE.
    strap_resample_i = 1'b1; tick(); strap_resample_i = 1'b0;
    check("resample_valid_low", 32'(strap_valid_o), 32'h0);
    check("resample_boot_held", 32'(strap_boot_o), 32'h0);
    check("resample_jtag_held", 32'(strap_jtag_spi_n_o), 32'h1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("resample_wait_valid", 32'(strap_valid_o), 32'h0);
    end
    tick();
    check("resample_latch_valid", 32'(strap_valid_o), 32'h1);
    check("resample_latch_boot",  32'(strap_boot_o), 32'h1);
    check("resample_latch_jtag",  32'(strap_jtag_spi_n_o), 32'h0);

    // Re-sample again, then a second request at WAIT count 10 restarts the wait.
    strap_resample_i = 1'b1; tick(); strap_resample_i = 1'b0;
    check("resample2_valid_low", 32'(strap_valid_o), 32'h0);
    repeat (10) begin
      tick();
      check("resample2_wait_valid", 32'(strap_valid_o), 32'h0);
    end
    strap_resample_i = 1'b1; tick(); strap_resample_i = 1'b0;
    check("restart_valid_low", 32'(strap_valid_o), 32'h0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("restart_wait_valid", 32'(strap_valid_o), 32'h0);
    end
    tick();
    check("restart_latch_valid", 32'(strap_valid_o), 32'h1);

    // Reset while in WAIT at count 8, with live data on the inputs.
    strap_resample_i = 1'b1; tick(); strap_resample_i = 1'b0;
    in_raw_i = 32'hFFFF_0000;
    repeat (8) tick();
    check("pre_reset_filt",  in_filt_o, 32'hFFFF_0000);
    check("pre_reset_valid", 32'(strap_valid_o), 32'h0);
    rst_i = 1'b1; tick(); rst_i = 1'b0; in_raw_i = '0;
    check_all_zero("mid_reset");
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("post_reset_wait_valid", 32'(strap_valid_o), 32'h0);
    end
    tick();
    check("post_reset_latch_valid", 32'(strap_valid_o), 32'h1);
    check("post_reset_latch_jtag",  32'(strap_jtag_spi_n_o), 32'h0);
    check("post_reset_latch_boot",  32'(strap_boot_o), 32'h1);

    // Bit 3 filtered, thresh 4: a 4-cycle glitch is rejected.
    filt_en_i = 32'h0000_0008; filt_thresh_i = 4'd4;
    in_raw_i[3] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) in_raw_i[3] = 1'b0;
      if (k == 1) check("glitch_sync_lag1", 32'(in_sync_o[3]), 32'h0);
      if (k == 2) check("glitch_sync_lag2", 32'(in_sync_o[3]), 32'h1);
      check("glitch_filt", 32'(in_filt_o[3]), 32'h0);
      check("glitch_rise", 32'(rise_o[3]), 32'h0);
    end

    // A held level is accepted 7 edges after the raw change, with a single pulse.
    in_raw_i[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("level_filt", 32'(in_filt_o[3]), 32'(k >= 7));
      check("level_rise", 32'(rise_o[3]), 32'(k == 7));
    end
    in_raw_i[3] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("level_fall_filt", 32'(in_filt_o[3]), 32'(k < 7));
      check("level_fall",      32'(fall_o[3]), 32'(k == 7));
    end

    // Bit 0 bypassed: toggling raw follows with 3-edge lag, alternating pulses.
    hist[0] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      in_raw_i[0] = ~in_raw_i[0];
      hist[n] = in_raw_i[0];
      tick();
      if (n >= 3) begin
        check("bypass_filt", 32'(in_filt_o[0]), 32'(hist[n-2]));
        check("bypass_rise", 32'(rise_o[0]), 32'(hist[n-2] & ~hist[n-3]));
        check("bypass_fall", 32'(fall_o[0]), 32'(~hist[n-2] & hist[n-3]));
        check("bypass_no_overlap", 32'(rise_o[0] & fall_o[0]), 32'h0);
      end
    end

    // Threshold lowered mid-count: bit 5 counted to 12 of 15, then thresh 5.
    filt_en_i = 32'h0000_0028; filt_thresh_i = 4'd15;
    in_raw_i[5] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check("thresh_count_filt", 32'(in_filt_o[5]), 32'h0);
    end
    filt_thresh_i = 4'd5;
    tick();
    check("thresh_lower_filt", 32'(in_filt_o[5]), 32'h1);
    check("thresh_lower_rise", 32'(rise_o[5]), 32'h1);

    // Random glitches on all bits against a per-bit reference model.
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    m_s1 = '0; m_s2 = '0; m_filt = '0; m_prev = '0;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 50 == 0) begin
        filt_en_i     = $urandom();
        filt_thresh_i = 4'($urandom_range(0, 6));
      end
      in_raw_i = in_raw_i ^ ($urandom() & $urandom() & $urandom());
      cap_en = filt_en_i; cap_th = filt_thresh_i; cap_raw = in_raw_i;
      tick();
      m_prev = m_filt;
      for (int i = 0; i < 32; i++) begin
        if (!cap_en[i]) begin
          m_filt[i] = m_s2[i];
          m_cnt[i]  = 0;
        end else if (m_s2[i] == m_filt[i]) begin
          m_cnt[i] = 0;
        end else if (m_cnt[i] >= int'(cap_th)) begin
          m_filt[i] = m_s2[i];
          m_cnt[i]  = 0;
        end else begin
          m_cnt[i]++;
        end
      end
      m_s2 = m_s1;
      m_s1 = cap_raw;
      check("rand_sync", in_sync_o, m_s2);
      check("rand_filt", in_filt_o, m_filt);
      check("rand_rise", rise_o, m_filt & ~m_prev);
      check("rand_fall", fall_o, ~m_filt & m_prev);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
